// File: rtl/vga_fb_pkg.sv
// Timing constants, fetch state encoding and derived line-buffer sizes for the framebuffer fetch arbiter.
package vga_fb_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned PIX_PER_WORD = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  function automatic int unsigned words_f(input int unsigned h_active, input int unsigned ppw);
    return h_active / ppw;
  endfunction

  function automatic int unsigned lb_aw_f(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

  localparam int unsigned WORDS   = words_f(H_ACTIVE, PIX_PER_WORD);
  localparam int unsigned LB_AW   = lb_aw_f(WORDS);
  localparam int unsigned COORD_W = $clog2(H_TOTAL) + 1;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Framebuffer read address generator: page base + target line base + word index, held in a register.
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] line,
  input  logic               page,
  output logic [ADDR_W-1:0]  addr
);

  localparam logic [ADDR_W-1:0] PAGE_BASE = ADDR_W'(V_ACTIVE * WORDS);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Constant shift-add of the line number; the word index is then accumulated one per read.
  function automatic logic [ADDR_W-1:0] line_base(input logic [COORD_W-1:0] ln);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (WORDS[b]) acc = acc + (ADDR_W'(ln) << b);
    end
    return acc;
  endfunction

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = (page ? PAGE_BASE : '0) + line_base(line);
    end else if (advance) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/vga_fb_fetch_arbiter.sv
// Shares a single-port framebuffer RAM between h-blank line prefetch and host writes.
// Optional page flipping is enabled with VGA_FB_PAGE_FLIP_EN.
module vga_fb_fetch_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned HOST_SLOT = 4
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] next_pixel_h,
  input  logic [COORD_W-1:0] next_pixel_v,
  input  logic               host_wr_valid,
  output logic               host_wr_ready,
  input  logic [ADDR_W-1:0]  host_wr_addr,
  input  logic [DATA_W-1:0]  host_wr_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               lb_we,
  output logic [LB_AW-1:0]   lb_addr,
  output logic [DATA_W-1:0]  lb_wdata,
  output logic               underrun
`ifdef VGA_FB_PAGE_FLIP_EN
  ,
  input  logic               page_sel,
  output logic               page_active
`endif
);

  localparam int unsigned     IW        = LB_AW - 1;
  localparam int unsigned     SW        = (HOST_SLOT > 1) ? $clog2(HOST_SLOT) : 1;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(HOST_SLOT - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(WORDS - 1);

  fetch_state_t       state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic               bank_q, bank_d;
  logic               ready_q, ready_d;
  logic               underrun_q, underrun_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [LB_AW-1:0]   rd_tag_q, rd_tag_d;
  logic               lb_we_q, lb_we_d;
  logic [LB_AW-1:0]   lb_addr_q, lb_addr_d;
`ifdef VGA_FB_PAGE_FLIP_EN
  logic               page_q, page_d;
`endif

  logic [COORD_W-1:0] tgt;
  logic               trig, grant, load, advance, page_ld;
  logic [ADDR_W-1:0]  rd_addr;

  vga_fb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (vga_clk),
    .rst_n   (reset_n),
    .load    (load),
    .advance (advance),
    .line    (tgt),
    .page    (page_ld),
    .addr    (rd_addr)
  );

  always_comb begin
    tgt  = (next_pixel_v == COORD_W'(V_TOTAL - 1)) ? '0 : next_pixel_v + COORD_W'(1);
    trig = (next_pixel_h == COORD_W'(H_ACTIVE)) && (tgt < COORD_W'(V_ACTIVE));

    state_d     = state_q;
    idx_d       = idx_q;
    slot_d      = slot_q;
    bank_d      = bank_q;
    underrun_d  = underrun_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rd_tag_d    = '0;
    load        = 1'b0;
    advance     = 1'b0;
    grant       = ready_q & host_wr_valid;
    lb_we_d     = mem_en_q & ~mem_we_q;
    lb_addr_d   = rd_tag_q;

`ifdef VGA_FB_PAGE_FLIP_EN
    page_d  = page_q;
    page_ld = page_q;
    if (trig && (tgt == '0)) begin
      page_d  = page_sel;
      page_ld = page_sel;
    end
`else
    page_ld = 1'b0;
`endif

    if (grant) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = host_wr_addr;
      mem_wdata_d = host_wr_data;
    end

    // A trigger always (re)starts at word 0; arriving mid-fetch means the old one was late.
    if (trig) begin
      if (state_q != IDLE) underrun_d = 1'b1;
      state_d = FETCH;
      idx_d   = '0;
      slot_d  = '0;
      bank_d  = tgt[0];
      load    = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (next_pixel_h == '0) begin
            underrun_d = 1'b1;
            state_d    = IDLE;
          end else begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
            if (!grant) begin
              mem_en_d   = 1'b1;
              mem_addr_d = rd_addr;
              rd_tag_d   = {bank_q, idx_q};
              advance    = 1'b1;
              idx_d      = idx_q + IW'(1);
              if (idx_q == IDX_LAST) state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (next_pixel_h == '0) underrun_d = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end

    ready_d = (state_d == IDLE) || ((state_d == FETCH) && (slot_d == SLOT_LAST));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      slot_q      <= '0;
      bank_q      <= 1'b0;
      ready_q     <= 1'b0;
      underrun_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_tag_q    <= '0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= '0;
`ifdef VGA_FB_PAGE_FLIP_EN
      page_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      slot_q      <= slot_d;
      bank_q      <= bank_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_tag_q    <= rd_tag_d;
      lb_we_q     <= lb_we_d;
      lb_addr_q   <= lb_addr_d;
`ifdef VGA_FB_PAGE_FLIP_EN
      page_q      <= page_d;
`endif
    end
  end

  assign host_wr_ready = ready_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign lb_we         = lb_we_q;
  assign lb_addr       = lb_addr_q;
  assign lb_wdata      = mem_rdata;
  assign underrun      = underrun_q;
`ifdef VGA_FB_PAGE_FLIP_EN
  assign page_active   = page_q;
`endif

endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// Directed self-checking bench for vga_fb_fetch_arbiter; covers VGA_FB_PAGE_FLIP_EN when defined.
module tb_vga_fb_fetch_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [10:0] next_pixel_h, next_pixel_v;
  logic        host_wr_valid, host_wr_ready;
  logic [16:0] host_wr_addr, mem_addr;
  logic [63:0] host_wr_data, mem_wdata, mem_rdata, lb_wdata;
  logic        mem_en, mem_we, lb_we, underrun;
  logic [7:0]  lb_addr;
`ifdef VGA_FB_PAGE_FLIP_EN
  logic        page_sel, page_active;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vga_fb_fetch_arbiter #(.DATA_W(64), .ADDR_W(17), .HOST_SLOT(4)) dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .next_pixel_h  (next_pixel_h),
    .next_pixel_v  (next_pixel_v),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .lb_we         (lb_we),
    .lb_addr       (lb_addr),
    .lb_wdata      (lb_wdata),
    .underrun      (underrun)
`ifdef VGA_FB_PAGE_FLIP_EN
    ,
    .page_sel      (page_sel),
    .page_active   (page_active)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [63:0] pat(input logic [16:0] a);
    return {32'hDEAD_0000, 15'd0, a};
  endfunction

  function automatic logic [16:0] h_addr(input int unsigned j);
    return 17'h1_0000 + 17'(j * 3);
  endfunction

  function automatic logic [63:0] h_data(input int unsigned j);
    return {32'hC0DE_0000 + j, 32'h0000_BEEF ^ j};
  endfunction

  // RAM model: read data one cycle after the strobe
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)                mem_rdata <= '0;
    else if (mem_en && !mem_we)  mem_rdata <= pat(mem_addr);
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    next_pixel_h = 11'd0;
    next_pixel_v = 11'd0;
    host_wr_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    next_pixel_h = 11'd0;
    next_pixel_v = 11'd0;
    host_wr_valid = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
`ifdef VGA_FB_PAGE_FLIP_EN
    page_sel = 1'b0;
`endif
    repeat (10) tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, underrun, host_wr_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h lbwe=%b lba=%h ur=%b rdy=%b, want all 0",
               mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, underrun, host_wr_ready);
    end
    reset_n = 1'b1;
    for (int unsigned i = 1; i <= 30; i++) begin
      next_pixel_h = 11'(i);
      tick();
      n_cmp++;
      if (mem_en !== 1'b0 || lb_we !== 1'b0 || host_wr_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL idle_after_reset[%0d]: got en=%b lbwe=%b rdy=%b, want 0 0 1", i, mem_en, lb_we, host_wr_ready);
      end
    end
  endtask

  task automatic test_line_fetch();
    next_pixel_v = 11'd9;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    for (int unsigned k = 0; k <= 80; k++) begin
      tick();
      n_cmp++;
      if (k < 80) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'(800 + k)) begin
          n_bad++;
          $display("FAIL fetch_rd[%0d]: got en=%b we=%b addr=%0d, want 1 0 %0d", k, mem_en, mem_we, mem_addr, 800 + k);
        end
      end else if (mem_en !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_end: got en=%b, want 0", mem_en);
      end
      if (k >= 1) begin
        n_cmp++;
        if (lb_we !== 1'b1 || lb_addr !== 8'(k - 1) || lb_wdata !== pat(17'(800 + k - 1))) begin
          n_bad++;
          $display("FAIL fetch_lb[%0d]: got we=%b addr=%h data=%h, want 1 %h %h",
                   k, lb_we, lb_addr, lb_wdata, 8'(k - 1), pat(17'(800 + k - 1)));
        end
      end
      if (k == 79 || k == 80) begin
        n_cmp++;
        if (host_wr_ready !== (k == 80)) begin
          n_bad++;
          $display("FAIL drain_ready[%0d]: got %b, want %b", k, host_wr_ready, (k == 80));
        end
      end
    end
    tick();
    n_cmp++;
    if (lb_we !== 1'b0 || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_done: got lbwe=%b ur=%b, want 0 0", lb_we, underrun);
    end
  endtask

  task automatic test_host_slots();
    int unsigned j, r;
    logic exp_rdy;
    j = 0;
    r = 0;
    next_pixel_v = 11'd19;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    host_wr_valid = 1'b1;
    host_wr_addr = h_addr(0);
    host_wr_data = h_data(0);
    for (int unsigned c = 0; c < 106; c++) begin
      exp_rdy = ((c % 4) == 3);
      n_cmp++;
      if (host_wr_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL slot_ready[%0d]: got %b, want %b", c, host_wr_ready, exp_rdy);
      end
      tick();
      n_cmp++;
      if (exp_rdy) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== h_addr(j) || mem_wdata !== h_data(j)) begin
          n_bad++;
          $display("FAIL host_wr[%0d]: got en=%b we=%b addr=%h data=%h, want 1 1 %h %h",
                   c, mem_en, mem_we, mem_addr, mem_wdata, h_addr(j), h_data(j));
        end
        j++;
        host_wr_addr = h_addr(j);
        host_wr_data = h_data(j);
      end else begin
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'(1600 + r)) begin
          n_bad++;
          $display("FAIL slot_rd[%0d]: got en=%b we=%b addr=%0d, want 1 0 %0d", c, mem_en, mem_we, mem_addr, 1600 + r);
        end
        r++;
      end
    end
    n_cmp++;
    if (host_wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL slot_drain_ready: got %b, want 0", host_wr_ready);
    end
    host_wr_valid = 1'b0;
    tick();
    n_cmp++;
    if (mem_en !== 1'b0 || host_wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL slot_done: got en=%b rdy=%b, want 0 1", mem_en, host_wr_ready);
    end
  endtask

  task automatic test_wrap_and_skip();
    next_pixel_v = 11'd524;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    for (int unsigned k = 0; k < 80; k++) begin
      tick();
      n_cmp++;
      if (mem_en !== 1'b1 || mem_addr !== 17'(k)) begin
        n_bad++;
        $display("FAIL wrap_rd[%0d]: got en=%b addr=%0d, want 1 %0d", k, mem_en, mem_addr, k);
      end
    end
    tick();
    n_cmp++;
    if (lb_we !== 1'b1 || lb_addr !== 8'd79) begin
      n_bad++;
      $display("FAIL wrap_lb_last: got we=%b addr=%h, want 1 4f", lb_we, lb_addr);
    end
    next_pixel_v = 11'd479;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (mem_en !== 1'b0 || host_wr_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL no_fetch_479[%0d]: got en=%b rdy=%b, want 0 1", k, mem_en, host_wr_ready);
      end
    end
  endtask

  task automatic test_deadline();
    do_reset();
    next_pixel_v = 11'd10;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    tick();
    tick();
    n_cmp++;
    if (mem_addr !== 17'd881 || lb_addr !== 8'h80 || lb_we !== 1'b1 || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL deadline_pre: got addr=%0d lba=%h lbwe=%b ur=%b, want 881 80 1 0", mem_addr, lb_addr, lb_we, underrun);
    end
    next_pixel_h = 11'd0;
    tick();
    n_cmp++;
    if (underrun !== 1'b1 || mem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL deadline_miss: got ur=%b en=%b, want 1 0", underrun, mem_en);
    end
    next_pixel_h = 11'd1;
    for (int unsigned k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (underrun !== 1'b1 || mem_en !== 1'b0) begin
        n_bad++;
        $display("FAIL underrun_sticky[%0d]: got ur=%b en=%b, want 1 0", k, underrun, mem_en);
      end
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_clear: got %b, want 0", underrun);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    next_pixel_v = 11'd30;
    next_pixel_h = 11'd640;
    tick();
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL retrig_first: got ur=%b, want 0", underrun);
    end
    tick();
    n_cmp++;
    if (underrun !== 1'b1 || mem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL retrig_second: got ur=%b en=%b, want 1 0", underrun, mem_en);
    end
    next_pixel_h = 11'd641;
    tick();
    n_cmp++;
    if (mem_en !== 1'b1 || mem_addr !== 17'd2480) begin
      n_bad++;
      $display("FAIL retrig_restart: got en=%b addr=%0d, want 1 2480", mem_en, mem_addr);
    end
    repeat (81) tick();
    n_cmp++;
    if (underrun !== 1'b1 || host_wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL retrig_done: got ur=%b rdy=%b, want 1 1", underrun, host_wr_ready);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    next_pixel_v = 11'd40;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    repeat (5) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (mem_en !== 1'b0 || underrun !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_abort[%0d]: got en=%b ur=%b, want 0 0", k, mem_en, underrun);
      end
    end
  endtask

`ifdef VGA_FB_PAGE_FLIP_EN
  task automatic test_page_flip();
    do_reset();
    page_sel = 1'b1;
    next_pixel_v = 11'd100;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    tick();
    n_cmp++;
    if (page_active !== 1'b0 || mem_addr !== 17'd8080) begin
      n_bad++;
      $display("FAIL page_midframe: got pa=%b addr=%0d, want 0 8080", page_active, mem_addr);
    end
    repeat (85) tick();
    next_pixel_v = 11'd524;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    n_cmp++;
    if (page_active !== 1'b1) begin
      n_bad++;
      $display("FAIL page_flip: got pa=%b, want 1", page_active);
    end
    for (int unsigned k = 0; k < 80; k++) begin
      tick();
      n_cmp++;
      if (mem_addr !== 17'(38400 + k)) begin
        n_bad++;
        $display("FAIL page_rd[%0d]: got addr=%0d, want %0d", k, mem_addr, 38400 + k);
      end
    end
    repeat (2) tick();
    page_sel = 1'b0;
    next_pixel_v = 11'd5;
    next_pixel_h = 11'd640;
    tick();
    next_pixel_h = 11'd641;
    tick();
    n_cmp++;
    if (page_active !== 1'b1 || mem_addr !== 17'd38880) begin
      n_bad++;
      $display("FAIL page_hold: got pa=%b addr=%0d, want 1 38880", page_active, mem_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_fetch();
    test_host_slots();
    test_wrap_and_skip();
    test_deadline();
    test_retrigger();
    test_reset_midfetch();
`ifdef VGA_FB_PAGE_FLIP_EN
    test_page_flip();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
